unary_add_nch: RTL and testbench



---
 rtl/unary_add_pkg.sv | 7 +
 rtl/popcount_n.sv | 13 +
 rtl/unary_add_nch.sv | 76 +++++++
 tb/tb_unary_add_nch.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/unary_add_pkg.sv
// unary_add_pkg: FSM state type and counter-width helper shared by the unary accumulator.
package unary_add_pkg;
  typedef enum logic [1:0] {S_ACC, S_DRAIN, S_EMPTY} unary_state_t;
  function automatic int cw_of(input int cap);
    return $clog2(cap + 1);
  endfunction
endpackage

// File: rtl/popcount_n.sv
// popcount_n: combinational population count of an N_CH-bit vector.
module popcount_n #(
  parameter int N_CH = 2,
  localparam int W = $clog2(N_CH + 1)
) (
  input  logic [N_CH-1:0] din_i,
  output logic [W-1:0]    cnt_o
);
  always_comb begin
    cnt_o = '0;
    for (int i = 0; i < N_CH; i++) cnt_o = cnt_o + W'(din_i[i]);
  end
endmodule

// File: rtl/unary_add_nch.sv
// unary_add_nch: multi-channel unary accumulator with serial unary drain; UNARY_ADD_SAT_EN selects saturating count with sticky c.
module unary_add_nch
  import unary_add_pkg::*;
#(
  parameter int N_CH = 2,
  parameter int CAP = 15,
  localparam int CW = cw_of(CAP)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            read_or_write,
  input  logic [N_CH-1:0] din,
  output logic            dout,
  output logic            c,
  output logic            done,
  output logic [CW-1:0]   count
);
  localparam int PW = $clog2(N_CH + 1);
  localparam int SW = (CW > PW ? CW : PW) + 1;
  unary_state_t state_q;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] pop;
  logic [SW-1:0] sum;
  logic ovf, c_q, c_d, dout_q, done_q;
  popcount_n #(.N_CH(N_CH)) u_pop (.din_i(din), .cnt_o(pop));
  assign sum = SW'(count_q) + SW'(pop);
  assign ovf = sum > SW'(CAP);
`ifdef UNARY_ADD_SAT_EN
  localparam bit SAT = 1'b1;
  always_comb count_d = ovf ? CW'(CAP) : CW'(sum);
  always_comb c_d = c_q | ovf;
`else
  localparam bit SAT = 1'b0;
  always_comb count_d = CW'(sum % SW'(CAP + 1));
  always_comb c_d = ovf;
`endif
  // In read mode a zero count (fresh or drained) fires done once, then parks in S_EMPTY.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_ACC;
      count_q <= '0;
      c_q     <= 1'b0;
      dout_q  <= 1'b0;
      done_q  <= 1'b0;
    end else if (!en) begin
      dout_q <= 1'b0;
      done_q <= 1'b0;
    end else if (!read_or_write) begin
      state_q <= S_ACC;
      count_q <= count_d;
      c_q     <= c_d;
      dout_q  <= 1'b0;
      done_q  <= 1'b0;
    end else if (state_q == S_EMPTY) begin
      c_q    <= SAT & c_q;
      dout_q <= 1'b0;
      done_q <= 1'b0;
    end else if (count_q != '0) begin
      state_q <= S_DRAIN;
      count_q <= count_q - CW'(1);
      c_q     <= SAT & c_q;
      dout_q  <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= S_EMPTY;
      c_q     <= 1'b0;
      dout_q  <= 1'b0;
      done_q  <= 1'b1;
    end
  end
  assign count = count_q;
  assign c     = c_q;
  assign dout  = dout_q;
  assign done  = done_q;
endmodule

// File: tb/tb_unary_add_nch.sv
// tb_unary_add_nch: table vectors, directed corner sequences and randomized run against a behavioural model.
module tb_unary_add_nch;
  localparam int N_CH = 2;
  localparam int CAP = 15;
  localparam int CW = $clog2(CAP + 1);
  logic clk = 1'b0, rst = 1'b1, en = 1'b0, rw = 1'b0;
  logic [N_CH-1:0] din = '0;
  logic dout, c, done;
  logic [CW-1:0] count;
  int checks = 0, errors = 0;
  int m_cnt = 0;
  bit m_fin = 0, m_dout = 0, m_done = 0, m_c = 0;
  typedef struct {
    bit r, e, w;
    logic [N_CH-1:0] d;
    int cnt;
    bit dout, done, c;
  } vec_t;
  vec_t vt[$];
  unary_add_nch #(.N_CH(N_CH), .CAP(CAP)) dut (
    .clk(clk), .rst(rst), .en(en), .read_or_write(rw), .din(din),
    .dout(dout), .c(c), .done(done), .count(count)
  );
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic model_step();
    int tot;
    if (rst) begin
      m_cnt = 0; m_fin = 0; m_dout = 0; m_done = 0; m_c = 0;
    end else if (!en) begin
      m_dout = 0; m_done = 0;
    end else if (!rw) begin
      tot = m_cnt + $countones(din);
      m_fin = 0; m_dout = 0; m_done = 0;
`ifdef UNARY_ADD_SAT_EN
      m_c = m_c || (tot > CAP);
      m_cnt = (tot > CAP) ? CAP : tot;
`else
      m_c = tot > CAP;
      m_cnt = tot % (CAP + 1);
`endif
    end else begin
      m_dout = !m_fin && m_cnt > 0;
      m_done = !m_fin && m_cnt == 0;
      if (m_dout) m_cnt--;
      if (m_done) m_fin = 1;
`ifdef UNARY_ADD_SAT_EN
      if (m_done) m_c = 0;
`else
      m_c = 0;
`endif
    end
  endtask
  task automatic drive(input bit r, input bit e, input bit w, input logic [N_CH-1:0] d);
    rst = r; en = e; rw = w; din = d;
    @(posedge clk);
    model_step();
    #1;
  endtask
  task automatic step(input bit r, input bit e, input bit w, input logic [N_CH-1:0] d);
    drive(r, e, w, d);
    check("count", count, m_cnt);
    check("dout", dout, m_dout);
    check("done", done, m_done);
    check("c", c, m_c);
  endtask
  task automatic add(input bit r, input bit e, input bit w, input logic [N_CH-1:0] d,
                     input int cnt, input bit o, input bit dn, input bit cc);
    vec_t v;
    v.r = r; v.e = e; v.w = w; v.d = d; v.cnt = cnt; v.dout = o; v.done = dn; v.c = cc;
    vt.push_back(v);
  endtask
  initial begin
    int ones, dn;
    bit w_cur;
`ifndef UNARY_ADD_SAT_EN
    add(1, 1, 0, 2'b00, 0, 0, 0, 0);
    add(1, 1, 0, 2'b00, 0, 0, 0, 0);
    for (int k = 1; k <= 9; k++) begin
      add(0, 1, 0, 2'b11, (2 * k) % 16, 0, 0, k == 8);
      add(0, 1, 0, 2'b00, (2 * k) % 16, 0, 0, 0);
    end
    add(0, 1, 1, 2'b00, 1, 1, 0, 0);
    add(0, 1, 1, 2'b00, 0, 1, 0, 0);
    add(0, 1, 1, 2'b00, 0, 0, 1, 0);
    add(0, 1, 1, 2'b00, 0, 0, 0, 0);
    add(0, 1, 1, 2'b11, 0, 0, 0, 0);
    foreach (vt[i]) begin
      drive(vt[i].r, vt[i].e, vt[i].w, vt[i].d);
      check($sformatf("vec%0d count", i), count, vt[i].cnt);
      check($sformatf("vec%0d dout", i), dout, vt[i].dout);
      check($sformatf("vec%0d done", i), done, vt[i].done);
      check($sformatf("vec%0d c", i), c, vt[i].c);
    end
`endif
    step(1, 1, 0, 2'b00);
    step(0, 1, 0, 2'b11); step(0, 1, 0, 2'b11); step(0, 1, 0, 2'b01);
    check("rd_acc5", count, 5);
    ones = 0; dn = 0;
    repeat (8) begin step(0, 1, 1, 2'b11); ones += dout; dn += done; end
    check("rd_ones", ones, 5);
    check("rd_done", dn, 1);
    step(1, 1, 0, 2'b00);
    repeat (3) step(0, 1, 0, 2'b11);
    check("mc_acc6", count, 6);
    repeat (3) step(0, 1, 1, 2'b00);
    check("mc_drain3", count, 3);
    step(0, 1, 0, 2'b01);
    check("mc_acc4", count, 4);
    step(0, 1, 1, 2'b00);
    check("mc_dout", dout, 1);
    step(1, 1, 1, 2'b00);
    check("rst_count", count, 0);
    check("rst_dout", dout, 0);
    step(1, 1, 0, 2'b00);
    step(0, 1, 0, 2'b11); step(0, 1, 0, 2'b11); step(0, 1, 0, 2'b01);
    step(0, 1, 1, 2'b00); step(0, 1, 1, 2'b00);
    check("eh_start3", count, 3);
    repeat (4) begin
      step(0, 0, 1, 2'b11);
      check("eh_count", count, 3);
      check("eh_dout", dout, 0);
    end
    ones = 0; dn = 0;
    repeat (5) begin step(0, 1, 1, 2'b00); ones += dout; dn += done; end
    check("eh_ones", ones, 3);
    check("eh_done", dn, 1);
    step(1, 1, 0, 2'b00);
    step(0, 1, 1, 2'b00);
    check("empty_done", done, 1);
    check("empty_dout", dout, 0);
    step(0, 1, 1, 2'b00);
    check("empty_done2", done, 0);
    w_cur = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 11) == 0) w_cur = ~w_cur;
      step($urandom_range(0, 99) == 0, $urandom_range(0, 9) != 0, w_cur, N_CH'($urandom));
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
